// File: rtl/serial_code_receiver_pkg.sv
// Shared types and frame constants for the serial code receiver.
package serial_code_receiver_pkg;

  localparam int CODE_BITS  = 5;
  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

endpackage

// File: rtl/rx_synchronizer.sv
// Flop chain bringing the asynchronous rx line into clk; resets to idle-high.
module rx_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/serial_code_receiver.sv
// Serial frame receiver (start, 5 code bits, parity, stop) with held parallel outputs.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | timing to the middle of the start bit to reject glitches
// DATA      | sampling the five code bits, MSB first
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit; commit code or flag framing error
// WAIT_IDLE | framing error seen, waiting for the line to return high
module serial_code_receiver
  import serial_code_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic b1,
  output logic b2,
  output logic b3,
  output logic b4,
  output logic b5,
  output logic b_par,
  output logic frame_valid,
  output logic frame_err,
  output logic busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(CODE_BITS - 1);

  logic                 rx_s;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2:0]           idx;
  logic [CODE_BITS-1:0] shadow;
  logic                 shadow_par;

  rx_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      shadow_par  <= 1'b0;
      b1          <= 1'b0;
      b2          <= 1'b0;
      b3          <= 1'b0;
      b4          <= 1'b0;
      b5          <= 1'b0;
      b_par       <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt         <= '0;
            shadow[idx] <= rx_s;
            if (idx == LAST_IDX) state <= PARITY;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            shadow_par <= rx_s;
            state      <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              // Commit the whole code at once so the decoder never sees a partial update.
              b1          <= shadow[0];
              b2          <= shadow[1];
              b3          <= shadow[2];
              b4          <= shadow[3];
              b5          <= shadow[4];
              b_par       <= shadow_par;
              frame_valid <= 1'b1;
              state       <= IDLE;
              busy        <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_code_receiver.md
Name: serial_code_receiver

Overview:
- Upstream neighbour of the 7-segment display decoder with parity check.
- Receives an asynchronous serial frame on one line: start bit, 5 code bits, 1 parity bit, stop bit.
- Presents the code as held, registered parallel outputs b1..b5 and b_par, which feed the display decoder directly.
- Performs no parity checking; parity is forwarded untouched for the downstream verifier.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be an even number ≥ 4.
- SYNC_STAGES, 2: flops in the rx input synchronizer; must be ≥ 2.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- rx  input  1  asynchronous serial line; idles high.
- b1  output  1  code bit 1 (MSB, first received).
- b2  output  1  code bit 2.
- b3  output  1  code bit 3.
- b4  output  1  code bit 4.
- b5  output  1  code bit 5 (LSB, last code bit received).
- b_par  output  1  received parity bit.
- frame_valid  output  1  one-cycle pulse when b1..b5/b_par have just been updated.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge): b1..b5, b_par, frame_valid, frame_err and busy all go to 0.
  - State goes to IDLE, counters clear, synchronizer flops are set to 1 (line idle).
  - A reset mid-frame aborts the frame; outputs are not updated from the partial data.
- rx passes through SYNC_STAGES flops; rx_s is the synchronized value. All decisions use rx_s.
- Bit counter cnt has width $clog2(CLKS_PER_BIT). Bit index idx is 3 bits wide, range 0..4.
- State machine (states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE):
  - IDLE: rx_s==0 → START, cnt=0.
  - START: at cnt==CLKS_PER_BIT/2-1, sample rx_s.
    - rx_s==1 (glitch / false start) → IDLE.
    - Otherwise → DATA, cnt=0, idx=0.
  - DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shadow shift register bit idx (idx 0 → b1, ..., idx 4 → b5) and reset cnt.
    - idx==4 → PARITY.
    - Otherwise idx++.
  - PARITY: at cnt==CLKS_PER_BIT-1, sample into shadow parity → STOP, cnt=0.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: copy shadow to b1..b5/b_par on that edge, pulse frame_valid for exactly 1 cycle → IDLE.
    - rx_s==0: outputs unchanged, pulse frame_err for 1 cycle → WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s==1 → IDLE. A break condition (line held low) produces exactly one frame_err.
- Sampling point: every bit is sampled at its mid-point relative to the detected start edge.
- Timing: a frame occupies 8 bit periods. frame_valid asserts 7.5 bit periods + SYNC_STAGES cycles after the rx falling edge.
- Outputs b1..b5/b_par are held indefinitely between valid frames. They change only in the same cycle frame_valid=1, so the downstream combinational decoder never sees a partially received code.
- busy=1 in START, DATA, PARITY, STOP and WAIT_IDLE.
- Back-to-back frames: a new start bit immediately after a stop bit is accepted from IDLE with no extra gap required.
- frame_valid and frame_err are never high in the same cycle.

Decomposition:
- Shared package:
  - State enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE).
  - CODE_BITS=5 constant.
  - Frame length constant FRAME_BITS=8.
- One sub-module: rx_synchronizer (SYNC_STAGES-deep flop chain, reset value 1, same clk/rst_n).
- Counter and FSM stay in the top module.

Test Plan (CLKS_PER_BIT=4, SYNC_STAGES=2):
- Reset: hold rst_n=0 for 3 cycles with rx=1 → b1..b5=0, b_par=0, frame_valid=0, frame_err=0, busy=0.
- Valid frame, code 00101 parity 0 (line 0,0,0,1,0,1,0,1) → single frame_valid pulse; b1..b5=0,0,1,0,1, b_par=0 held; busy back to 0.
- Frame code 11111 parity 1, followed immediately by code 00000 parity 0 with no idle gap → two frame_valid pulses, 32 cycles apart; outputs 11111/1, then 00000/0.
- Stop bit driven 0 (code 10001) → one frame_err pulse, outputs keep the previous value, busy stays high until rx returns to 1.
- rx low for 1 cycle only (glitch) → return to IDLE after the START sample; no pulses; outputs unchanged.
- rst_n asserted during DATA bit 3 of frame 01010 → outputs stay at their reset value of 0; the next full frame 00011/0 is received correctly.
